// File: rtl/wf8_pkg.sv
// Shared WF8 core definitions: comparator flag layout,
// branch condition codes and branch-resolve FSM states.
package wf8_pkg;

  localparam int BC_FLAG_COUNT = 2;
  localparam int BC_FLAG_GT    = 1;
  localparam int BC_FLAG_EQ    = 0;

  typedef enum logic [2:0] {
    BEQ     = 3'd0,
    BNE     = 3'd1,
    BGT     = 3'd2,
    BLT     = 3'd3,
    BGE     = 3'd4,
    BLE     = 3'd5,
    BAL     = 3'd6,
    BR_RSVD = 3'd7
  } br_cond_e;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FLAGS = 2'd1,
    REDIRECT   = 2'd2,
    FLUSH      = 2'd3
  } br_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator: (cond, {GT,EQ}) -> taken.
// Shared by branch resolution and future predication logic.
module branch_cond_eval
  import wf8_pkg::*;
(
  input  br_cond_e                 cond,
  input  logic [BC_FLAG_COUNT-1:0] flags,
  output logic                     taken
);

  logic gt;
  logic eq;

  assign gt = flags[BC_FLAG_GT];
  assign eq = flags[BC_FLAG_EQ];

  always_comb begin
    taken = 1'b0;
    unique case (cond)
      BEQ:     taken = eq;
      BNE:     taken = ~eq;
      BGT:     taken = gt;
      BLT:     taken = ~gt & ~eq;
      BGE:     taken = gt | eq;
      BLE:     taken = ~gt;
      BAL:     taken = 1'b1;
      BR_RSVD: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// WF8 branch resolution: flag wait, PC redirect handshake, fixed flush.
// Optional BRANCH_LINK_EN adds link-address reporting on taken branches.
module branch_resolve
  import wf8_pkg::*;
#(
  parameter int PC_WIDTH     = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     br_valid,
  output logic                     br_ready,
  input  br_cond_e                 br_cond,
  input  logic [PC_WIDTH-1:0]      br_target,
  input  logic [PC_WIDTH-1:0]      br_pc,
`ifdef BRANCH_LINK_EN
  input  logic                     br_link,
  output logic                     link_valid,
  output logic [PC_WIDTH-1:0]      link_addr,
`endif
  input  logic                     flag_valid,
  input  logic [BC_FLAG_COUNT-1:0] bc_flags,
  output logic                     redirect_valid,
  input  logic                     redirect_ready,
  output logic [PC_WIDTH-1:0]      redirect_pc,
  output logic                     flush,
  output logic                     resolved,
  output logic                     taken
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  br_state_e             state;
  logic [2:0]            flush_cnt;
  br_cond_e              cond_q;
  logic [PC_WIDTH-1:0]   target_q;

  logic                  in_idle;
  logic                  in_wait;
  logic                  accept;
  logic                  go;
  logic                  eval_taken;
  br_cond_e              eval_cond;
  logic [PC_WIDTH-1:0]   dest;

  assign in_idle = (state == IDLE);
  assign in_wait = (state == WAIT_FLAGS);
  assign accept  = in_idle & br_valid;

  // In IDLE the incoming request is evaluated before it is captured
  assign eval_cond = in_idle ? br_cond : cond_q;
  assign dest      = in_idle ? br_target : target_q;

  assign go = (accept & ((br_cond == BAL) | flag_valid))
            | (in_wait & flag_valid);

  branch_cond_eval u_eval (
    .cond  (eval_cond),
    .flags (bc_flags),
    .taken (eval_taken)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      flush_cnt      <= '0;
      br_ready       <= 1'b1;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      resolved       <= 1'b0;
      taken          <= 1'b0;
    end else begin
      resolved <= 1'b0;
      if (go) begin
        resolved <= 1'b1;
        taken    <= eval_taken;
        if (eval_taken) begin
          state          <= REDIRECT;
          br_ready       <= 1'b0;
          redirect_valid <= 1'b1;
          redirect_pc    <= dest;
        end else begin
          state    <= IDLE;
          br_ready <= 1'b1;
        end
      end else begin
        unique case (state)
          IDLE: begin
            if (br_valid) begin
              state    <= WAIT_FLAGS;
              br_ready <= 1'b0;
            end
          end
          WAIT_FLAGS: ;
          REDIRECT: begin
            if (redirect_ready) begin
              redirect_valid <= 1'b0;
              if (FLUSH_CYCLES == 0) begin
                state    <= IDLE;
                br_ready <= 1'b1;
              end else begin
                state     <= FLUSH;
                flush     <= 1'b1;
                flush_cnt <= FLUSH_LOAD;
              end
            end
          end
          FLUSH: begin
            if (flush_cnt == 3'd1) begin
              state    <= IDLE;
              flush    <= 1'b0;
              br_ready <= 1'b1;
            end else begin
              flush_cnt <= flush_cnt - 3'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef BRANCH_LINK_EN
  logic                link_q;
  logic [PC_WIDTH-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cond_q   <= BEQ;
      target_q <= '0;
      link_q   <= 1'b0;
      pc_q     <= '0;
    end else if (accept) begin
      cond_q   <= br_cond;
      target_q <= br_target;
      link_q   <= br_link;
      pc_q     <= br_pc;
    end
  end

  // Only taken branches reach REDIRECT, so no outcome term is needed
  assign link_valid = (state == REDIRECT) & redirect_ready & link_q;
  assign link_addr  = pc_q + PC_WIDTH'(1);
`else
  logic unused_br_pc;

  assign unused_br_pc = ^br_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      cond_q   <= BEQ;
      target_q <= '0;
    end else if (accept) begin
      cond_q   <= br_cond;
      target_q <= br_target;
    end
  end
`endif

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Branch resolution unit for the WF8 8-bit core. It accepts a conditional-branch request from the decoder and the GT/EQ compare flags from the ALU branch comparator. It decides whether the branch is taken and, for a taken branch, drives a PC redirect to fetch using a valid/ready handshake, followed by a fixed-length pipeline flush. It is the consumer end of the comparator's flag interface.

## Interface
Parameters:
- PC_WIDTH, 8, width of PC and branch target
- FLUSH_CYCLES, 2, cycles `flush` stays high after a redirect is accepted; 0 to 7 legal

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- br_valid  in  1  decoder presents a branch
- br_ready  out  1  unit can accept a branch
- br_cond  in  3  condition code (package enum)
- br_target  in  PC_WIDTH  branch destination
- br_pc  in  PC_WIDTH  PC of the branch instruction
- flag_valid  in  1  `bc_flags` valid this cycle
- bc_flags  in  BC_FLAG_COUNT  {GT, EQ}, indexed by package constants
- redirect_valid  out  1  redirect request to fetch
- redirect_ready  in  1  fetch accepts the redirect
- redirect_pc  out  PC_WIDTH  new PC
- flush  out  1  kill younger in-flight instructions
- resolved  out  1  one-cycle pulse when a branch is resolved
- taken  out  1  outcome; qualified by `resolved`

## Operation
- Condition codes: BEQ = EQ; BNE = !EQ; BGT = GT; BLT = !GT & !EQ; BGE = GT | EQ; BLE = !GT; BAL = 1. Code 7 is reserved and resolves as not-taken.
- States: IDLE, WAIT_FLAGS, REDIRECT, FLUSH.
- IDLE:
  - `br_ready` = 1.
  - On `br_valid`, capture cond, target and pc.
  - If cond is BAL, or `flag_valid` is high in the same cycle, resolve immediately using the incoming flags.
  - Otherwise go to WAIT_FLAGS.
- WAIT_FLAGS:
  - `br_ready` = 0.
  - On the first `flag_valid`, resolve using those flags.
- Resolve:
  - Register `resolved` = 1 and `taken` = the condition result.
  - Taken goes to REDIRECT. Not-taken goes to IDLE.
- REDIRECT:
  - `redirect_valid` = 1 and `redirect_pc` = the captured target.
  - Both are held stable until `redirect_ready`.
  - On handshake, go to FLUSH (counter loaded with FLUSH_CYCLES), or to IDLE if FLUSH_CYCLES = 0.
- FLUSH:
  - `flush` = 1; the counter decrements each cycle.
  - Leave for IDLE in the cycle the counter reaches 1.
- `flag_valid` in IDLE without `br_valid`, or in REDIRECT/FLUSH, is ignored. Flags are never stored for a later branch.
- `br_ready` is low in every state except IDLE.
- Reset in any state: return to IDLE in the next cycle and abort any pending redirect or flush.

## Timing
- Reset values: `br_ready`=1 (IDLE), `redirect_valid`=0, `redirect_pc`=0, `flush`=0, `resolved`=0, `taken`=0.
- Branch accepted with flags at cycle T:
  - `resolved` pulses at T+1.
  - Taken: `redirect_valid` is first high at T+1.
  - Not-taken: `br_ready` is high again at T+1.
- Branch waiting for flags: flags arriving at cycle U give `resolved` at U+1.
- Redirect handshake at cycle R: `flush` is high for R+1 through R+FLUSH_CYCLES, then `br_ready` is high at R+FLUSH_CYCLES+1.
- A redirect held back by `redirect_ready`=0 may stall indefinitely; no timeout.

## Configuration
- BRANCH_LINK_EN, when defined:
  - Adds input `br_link` (1 bit, captured at acceptance) and outputs `link_valid` (1) and `link_addr` (PC_WIDTH).
  - On a taken branch with link set, `link_valid` pulses in the redirect-handshake cycle with `link_addr` = br_pc + 1, mod 2^PC_WIDTH (0xFF+1 wraps to 0x00).
- Without the macro: these ports do not exist, and no link logic or register is present.

## Structure
- Shared package `wf8_pkg`:
  - `BC_FLAG_COUNT`, `BC_FLAG_GT`, `BC_FLAG_EQ`
  - the br_cond enum (BEQ=0, BNE, BGT, BLT, BGE, BLE, BAL=6)
  - the state enum
- Sub-module `branch_cond_eval`: purely combinational mapping of (cond, flags) to taken. It is reused by any future predication logic.

## Test plan
- BEQ, flags EQ=1 GT=0 with `flag_valid` in the accept cycle, target 0x40, `redirect_ready`=1 → `resolved`/`taken`=1 at T+1; `redirect_pc`=0x40; `flush` high 2 cycles; `br_ready` back at T+4.
- BNE accepted with no flags, flags EQ=1 arrive 3 cycles later → stays in WAIT_FLAGS; `resolved`=1, `taken`=0 one cycle after flags; no redirect, no flush.
- BLT with GT=0 EQ=0, `redirect_ready` held low 5 cycles → `redirect_valid` and `redirect_pc` stable for all 5 cycles; flush starts the cycle after `redirect_ready` rises.
- BAL with `flag_valid`=0 → taken without waiting; also run with FLUSH_CYCLES=0 → IDLE directly after the handshake.
- `rst` asserted mid-FLUSH and mid-REDIRECT → next cycle `flush`=0, `redirect_valid`=0, `br_ready`=1.
- BRANCH_LINK_EN, BGE taken, br_pc=0xFF, link=1 → `link_valid` pulses at the handshake with `link_addr`=0x00; with link=0, no pulse.
